// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM state type and byte classifier for the note parser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE_DATA     = 2'd0,
        BYTE_STATUS   = 2'd1,
        BYTE_SYSCOM   = 2'd2,
        BYTE_REALTIME = 2'd3
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        if (!b[7])            return BYTE_DATA;
        else if (b >= 8'hF8)  return BYTE_REALTIME;
        else if (b >= 8'hF0)  return BYTE_SYSCOM;
        else                  return BYTE_STATUS;
    endfunction

endpackage

// File: rtl/midi_note_parser_if.sv
// Byte-in / note-out signal bundle of the MIDI note parser, for benches and wrappers.
interface midi_note_parser_if;

    logic [7:0] midiByte;
    logic       midiByteValid;
    logic [7:0] midiNoteNumber;
    logic [6:0] noteVelocity;
    logic       noteGate;
    logic       noteEvent;

    modport master (
        output midiByte, midiByteValid,
        input  midiNoteNumber, noteVelocity, noteGate, noteEvent
    );

    modport slave (
        input  midiByte, midiByteValid,
        output midiNoteNumber, noteVelocity, noteGate, noteEvent
    );

endinterface

// File: rtl/midi_note_parser.sv
// Mono, last-note-priority MIDI note parser: tracks running status, skips non-note
// messages and drives a registered note number / velocity / gate with a change pulse.
module midi_note_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'h0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] midiByte,
    input  logic       midiByteValid,
    output logic [7:0] midiNoteNumber,
    output logic [6:0] noteVelocity,
    output logic       noteGate,
    output logic       noteEvent
);

    state_e      state_q;
    logic [7:0]  status_q;
    logic [6:0]  d1_q;
    logic [6:0]  note_q;
    logic [6:0]  vel_q;
    logic        gate_q;
    logic        event_q;

    byte_class_e byte_class;
    logic        relevant;
    logic        one_data;
    logic        is_note_on;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can form.
    always_comb begin
        byte_class = classify(midiByte);
        relevant   = ((status_q[7:4] == NOTE_ON) || (status_q[7:4] == NOTE_OFF)) &&
                     (OMNI || (status_q[3:0] == CHANNEL));
        one_data   = (status_q[7:4] == PROG_CHG) || (status_q[7:4] == CHAN_PRESS);
        is_note_on = (status_q[7:4] == NOTE_ON) && (midiByte[6:0] != 7'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            d1_q     <= 7'd0;
            note_q   <= 7'd0;
            vel_q    <= 7'd0;
            gate_q   <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            event_q <= 1'b0;
            if (midiByteValid) begin
                unique case (byte_class)
                    BYTE_REALTIME: ;
                    BYTE_SYSCOM: begin
                        state_q  <= IDLE;
                        status_q <= 8'h00;
                    end
                    BYTE_STATUS: begin
                        state_q  <= WAIT_D1;
                        status_q <= midiByte;
                        d1_q     <= 7'd0;
                    end
                    BYTE_DATA: begin
                        unique case (state_q)
                            IDLE: ;
                            WAIT_D1: begin
                                // Program change / channel pressure complete on one data byte.
                                if (!one_data) begin
                                    d1_q    <= midiByte[6:0];
                                    state_q <= WAIT_D2;
                                end
                            end
                            WAIT_D2: begin
                                state_q <= WAIT_D1;
                                if (relevant) begin
                                    if (is_note_on) begin
                                        note_q  <= d1_q;
                                        vel_q   <= midiByte[6:0];
                                        gate_q  <= 1'b1;
                                        event_q <= 1'b1;
                                    end else if (gate_q && (d1_q == note_q)) begin
                                        gate_q  <= 1'b0;
                                        event_q <= 1'b1;
                                    end
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign midiNoteNumber = {1'b0, note_q};
    assign noteVelocity   = vel_q;
    assign noteGate       = gate_q;
    assign noteEvent      = event_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench: an OMNI instance and a channel-1 instance share one byte stream and
// are compared every cycle against a message-level model, plus directed literal scenarios.
module tb_midi_note_parser;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    midi_note_parser_if bus0 ();
    midi_note_parser_if bus1 ();

    midi_note_parser #(.OMNI(1'b1), .CHANNEL(4'h0)) dut0 (
        .clk(clk), .resetn(resetn),
        .midiByte(bus0.midiByte), .midiByteValid(bus0.midiByteValid),
        .midiNoteNumber(bus0.midiNoteNumber), .noteVelocity(bus0.noteVelocity),
        .noteGate(bus0.noteGate), .noteEvent(bus0.noteEvent)
    );

    midi_note_parser #(.OMNI(1'b0), .CHANNEL(4'h1)) dut1 (
        .clk(clk), .resetn(resetn),
        .midiByte(bus1.midiByte), .midiByteValid(bus1.midiByteValid),
        .midiNoteNumber(bus1.midiNoteNumber), .noteVelocity(bus1.noteVelocity),
        .noteGate(bus1.noteGate), .noteEvent(bus1.noteEvent)
    );

    int checks = 0;
    int errors = 0;
    int ev_cnt0 = 0;
    int ev_cnt1 = 0;
    bit cmp_en = 1'b0;

    // Message-level model: running status plus the data bytes collected so far.
    bit         m_have   [2];
    logic [7:0] m_status [2];
    logic [6:0] m_d      [2][2];
    int         m_n      [2];
    logic [6:0] m_note   [2];
    logic [6:0] m_vel    [2];
    bit         m_gate   [2];
    bit         m_ev     [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_have[k] = 1'b0; m_status[k] = 8'h00; m_n[k] = 0;
            m_note[k] = 7'd0; m_vel[k] = 7'd0; m_gate[k] = 1'b0; m_ev[k] = 1'b0;
        end
    endfunction

    function automatic void model_byte(input int k, input logic [7:0] b);
        int  need;
        bit  accepts;
        bit  on;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_have[k] = 1'b0; m_n[k] = 0; return; end
        if (b[7]) begin m_have[k] = 1'b1; m_status[k] = b; m_n[k] = 0; return; end
        if (!m_have[k]) return;
        m_d[k][m_n[k]] = b[6:0];
        m_n[k]++;
        need = (m_status[k][7:4] == 4'hC || m_status[k][7:4] == 4'hD) ? 1 : 2;
        if (m_n[k] < need) return;
        m_n[k] = 0;
        if (need != 2) return;
        if (m_status[k][7:4] != 4'h8 && m_status[k][7:4] != 4'h9) return;
        accepts = (k == 0) ? 1'b1 : (m_status[k][3:0] == 4'h1);
        if (!accepts) return;
        on = (m_status[k][7:4] == 4'h9) && (m_d[k][1] != 7'd0);
        if (on) begin
            m_note[k] = m_d[k][0]; m_vel[k] = m_d[k][1]; m_gate[k] = 1'b1; m_ev[k] = 1'b1;
        end else if (m_gate[k] && m_d[k][0] == m_note[k]) begin
            m_gate[k] = 1'b0; m_ev[k] = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("note0",  bus0.midiNoteNumber, {25'd0, 1'b0, m_note[0]});
            check("vel0",   bus0.noteVelocity,   {25'd0, m_vel[0]});
            check("gate0",  bus0.noteGate,       {31'd0, m_gate[0]});
            check("event0", bus0.noteEvent,      {31'd0, m_ev[0]});
            check("note1",  bus1.midiNoteNumber, {25'd0, 1'b0, m_note[1]});
            check("vel1",   bus1.noteVelocity,   {25'd0, m_vel[1]});
            check("gate1",  bus1.noteGate,       {31'd0, m_gate[1]});
            check("event1", bus1.noteEvent,      {31'd0, m_ev[1]});
            ev_cnt0 += int'(bus0.noteEvent);
            ev_cnt1 += int'(bus1.noteEvent);
        end
    end

    // One clock: drive at the negedge, model after the posedge, return just past the compare.
    task automatic cycle(input logic v, input logic [7:0] b);
        bus0.midiByte = b; bus0.midiByteValid = v;
        bus1.midiByte = b; bus1.midiByteValid = v;
        @(posedge clk);
        #1;
        m_ev[0] = 1'b0; m_ev[1] = 1'b0;
        if (v) begin model_byte(0, b); model_byte(1, b); end
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle();
        cycle(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic reset_pulse();
        bus0.midiByteValid = 1'b0; bus1.midiByteValid = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0, 1, 2: return 8'h90;
            3:       return 8'h80;
            4:       return 8'h91;
            5:       return 8'h81;
            6:       return 8'hB0;
            7:       return 8'hC0;
            8:       return 8'hD1;
            9:       return ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hF2;
            10:      return ($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hFE;
            default: begin
                r = $urandom_range(0, 5);
                if (r == 0) return 8'h00;
                if (r == 5) return 8'($urandom_range(0, 127));
                return 8'(8'h3C + 2 * (r - 1));
            end
        endcase
    endfunction

    int e0;
    int e1;

    initial begin
        bus0.midiByte = 8'h00; bus0.midiByteValid = 1'b0;
        bus1.midiByte = 8'h00; bus1.midiByteValid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        cmp_en = 1'b1;

        check("reset_note", bus0.midiNoteNumber, 32'h00);
        check("reset_gate", bus0.noteGate, 32'h0);
        check("reset_event", bus0.noteEvent, 32'h0);

        // Basic note-on, then a running-status second note.
        e0 = ev_cnt0;
        send(8'h90); send(8'h3C); send(8'h64);
        check("on_note", bus0.midiNoteNumber, 32'h3C);
        check("on_vel", bus0.noteVelocity, 32'h64);
        check("on_gate", bus0.noteGate, 32'h1);
        check("on_event", bus0.noteEvent, 32'h1);
        idle();
        check("on_event_low", bus0.noteEvent, 32'h0);
        check("on_ch1_filtered", bus1.noteGate, 32'h0);
        send(8'h40); send(8'h50); idle();
        check("rs_note", bus0.midiNoteNumber, 32'h40);
        check("rs_vel", bus0.noteVelocity, 32'h50);
        check("rs_gate", bus0.noteGate, 32'h1);
        check("rs_events", e0 == ev_cnt0 - 2, 32'h1);

        // Note-off for another note is ignored; matching note-on vel 0 releases.
        send(8'h90); send(8'h3C); send(8'h64);
        e0 = ev_cnt0;
        send(8'h80); send(8'h3E); send(8'h00); idle();
        check("off_other_gate", bus0.noteGate, 32'h1);
        check("off_other_events", ev_cnt0 - e0, 32'd0);
        send(8'h90); send(8'h3C); send(8'h00);
        check("off_gate", bus0.noteGate, 32'h0);
        check("off_event", bus0.noteEvent, 32'h1);
        check("off_note_held", bus0.midiNoteNumber, 32'h3C);
        check("off_vel_held", bus0.noteVelocity, 32'h64);

        // Realtime byte inside a message is transparent; a CC interrupting one is not a note.
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        check("rt_note", bus0.midiNoteNumber, 32'h3C);
        check("rt_vel", bus0.noteVelocity, 32'h64);
        check("rt_gate", bus0.noteGate, 32'h1);
        check("rt_event", bus0.noteEvent, 32'h1);
        send(8'h3C); send(8'h00);
        check("rt_release", bus0.noteGate, 32'h0);
        e0 = ev_cnt0;
        send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h64); idle();
        check("cc_events", ev_cnt0 - e0, 32'd0);
        check("cc_gate", bus0.noteGate, 32'h0);

        // Channel filter on the OMNI=0, CHANNEL=1 instance.
        e1 = ev_cnt1;
        send(8'h90); send(8'h3C); send(8'h64); idle();
        check("ch0_ignored_gate", bus1.noteGate, 32'h0);
        check("ch0_ignored_events", ev_cnt1 - e1, 32'd0);
        send(8'h91); send(8'h3C); send(8'h64);
        check("ch1_gate", bus1.noteGate, 32'h1);
        check("ch1_note", bus1.midiNoteNumber, 32'h3C);
        check("ch1_vel", bus1.noteVelocity, 32'h64);

        // Reset mid-message drops the partial note-on.
        send(8'h90); send(8'h3C);
        reset_pulse();
        e0 = ev_cnt0;
        send(8'h64); idle();
        check("rst_note", bus0.midiNoteNumber, 32'h00);
        check("rst_vel", bus0.noteVelocity, 32'h00);
        check("rst_gate", bus0.noteGate, 32'h0);
        check("rst_events", ev_cnt0 - e0, 32'd0);

        // Randomized stream with back-to-back strobes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 997 == 996) reset_pulse();
            if ($urandom_range(0, 9) < 6) send(rand_byte());
            else idle();
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
